// File: rtl/debounce_bcd7_pkg.sv
// debounce_bcd7_pkg -- shared types and constants for the debounced key
// plus seven-segment decoder block.
//   seg_t             : segment vector, index 0 = a ... index 6 = g, 1 = lit
//   SEG_0..SEG_9      : decimal digit glyphs
//   SEG_A..SEG_F      : hex glyphs (used only when BCD7_HEX_EN is defined)
//   SEG_BLANK         : all segments off
//   DB_CYCLES_DEFAULT : default debounce qualification length (10 ms @ 50 MHz)
package debounce_bcd7_pkg;

    typedef logic [0:6] seg_t;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_B     = 7'b0011111;
    localparam seg_t SEG_C     = 7'b1001110;
    localparam seg_t SEG_D     = 7'b0111101;
    localparam seg_t SEG_E     = 7'b1001111;
    localparam seg_t SEG_F     = 7'b1000111;
    localparam seg_t SEG_BLANK = 7'b0000000;

    localparam int DB_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/bcd7_decoder.sv
// bcd7_decoder -- purely combinational digit to seven-segment decoder.
// Ports:
//   din  [3:0] : binary/BCD digit
//   dout [0:6] : segments a..g, active-high
// Configuration macro BCD7_HEX_EN: when defined, 10..15 show A b C d E F;
// otherwise they blank the display.
module bcd7_decoder
    import debounce_bcd7_pkg::*;
(
    input  logic [3:0] din,
    output logic [0:6] dout
);

    always_comb begin
        dout = SEG_BLANK;
        case (din)
            4'd0:    dout = SEG_0;
            4'd1:    dout = SEG_1;
            4'd2:    dout = SEG_2;
            4'd3:    dout = SEG_3;
            4'd4:    dout = SEG_4;
            4'd5:    dout = SEG_5;
            4'd6:    dout = SEG_6;
            4'd7:    dout = SEG_7;
            4'd8:    dout = SEG_8;
            4'd9:    dout = SEG_9;
`ifdef BCD7_HEX_EN
            4'd10:   dout = SEG_A;
            4'd11:   dout = SEG_B;
            4'd12:   dout = SEG_C;
            4'd13:   dout = SEG_D;
            4'd14:   dout = SEG_E;
            4'd15:   dout = SEG_F;
`else
            default: dout = SEG_BLANK;
`endif
        endcase
    end

endmodule

// File: rtl/debounce_bcd7.sv
// debounce_bcd7 -- push-button debouncer plus seven-segment digit decoder.
// Parameters:
//   DB_CYCLES   (>= 1) : consecutive stable clocks before key_o follows
//   SYNC_STAGES (>= 2) : synchronizer depth on key_i
// Ports:
//   clk         : system clock, rising edge
//   reset       : asynchronous, active-high; deassert synchronously to clk
//   key_i       : raw asynchronous button level
//   key_o       : debounced, registered level
//   din  [3:0]  : digit to display
//   dout [0:6]  : segments a..g, active-high, combinational from din
// Configuration macro BCD7_HEX_EN is consumed by bcd7_decoder.
// Latency from a clean key_i edge to key_o is SYNC_STAGES + DB_CYCLES clocks.
module debounce_bcd7
    import debounce_bcd7_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_i,
    output logic       key_o,
    input  logic [3:0] din,
    output logic [0:6] dout
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    // Counter value on the clock before it would reach DB_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   key_q;
    logic                   key_d;
    logic                   key_smp;

    assign sync_d  = {sync_q[SYNC_STAGES-2:0], key_i};
    assign key_smp = sync_q[SYNC_STAGES-1];

    // Any clock where the sampled key agrees with key_o clears the count,
    // so a bounce shorter than DB_CYCLES never accumulates. Reaching the
    // terminal value updates key_o and clears, so the counter cannot wrap.
    always_comb begin
        cnt_d = '0;
        key_d = key_q;
        if (key_smp != key_q) begin
            if (cnt_q == CNT_LAST) begin
                key_d = key_smp;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            key_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            key_q  <= key_d;
        end
    end

    assign key_o = key_q;

    bcd7_decoder u_dec (
        .din  (din),
        .dout (dout)
    );

endmodule

// File: tb/tb_debounce_bcd7.sv
module tb_debounce_bcd7;

    localparam int DB = 4;
    localparam int SS = 2;
    localparam int HN = SS + DB;

    logic       clk;
    logic       reset;
    logic       key_i;
    logic       key_o;
    logic [3:0] din;
    logic [0:6] dout;

    int n_vec;
    int n_err;

    // Reference: hist[k] is the key_i level seen k clocks ago (hist[0] = this
    // clock). key_o flips on a clock where the DB levels that have just left
    // the SS-deep synchronizer all disagree with the current output.
    logic       hist [HN];
    logic       m_out;
    logic [6:0] exp_seg [16];

    debounce_bcd7 #(
        .DB_CYCLES   (DB),
        .SYNC_STAGES (SS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .key_i (key_i),
        .key_o (key_o),
        .din   (din),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit all_diff;
        if (reset) begin
            for (int k = 0; k < HN; k++) hist[k] = 1'b0;
            m_out = 1'b0;
        end else begin
            for (int k = HN - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = key_i;
            all_diff = 1'b1;
            for (int k = SS; k < HN; k++)
                if (hist[k] == m_out) all_diff = 1'b0;
            if (all_diff) m_out = ~m_out;
        end
    endtask

    // One clock: update model at the edge, check key_o 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("key_o", {6'd0, key_o}, {6'd0, m_out});
    endtask

    // Count clocks until key_o changes from its current value (bound 20).
    task automatic latency(output int lat);
        logic start;
        start = key_o;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (key_o !== start && lat < 0) lat = i;
        end
    endtask

    initial begin
        int lat;
        int run;
        logic lvl;

        n_vec = 0;
        n_err = 0;
        exp_seg[0]  = 7'b1111110; exp_seg[1]  = 7'b0110000;
        exp_seg[2]  = 7'b1101101; exp_seg[3]  = 7'b1111001;
        exp_seg[4]  = 7'b0110011; exp_seg[5]  = 7'b1011011;
        exp_seg[6]  = 7'b1011111; exp_seg[7]  = 7'b1110000;
        exp_seg[8]  = 7'b1111111; exp_seg[9]  = 7'b1111011;
`ifdef BCD7_HEX_EN
        exp_seg[10] = 7'b1110111; exp_seg[11] = 7'b0011111;
        exp_seg[12] = 7'b1001110; exp_seg[13] = 7'b0111101;
        exp_seg[14] = 7'b1001111; exp_seg[15] = 7'b1000111;
`else
        for (int d = 10; d < 16; d++) exp_seg[d] = 7'b0000000;
`endif
        for (int k = 0; k < HN; k++) hist[k] = 1'b0;
        m_out = 1'b0;

        // Reset asserted with key_i high: key_o low immediately.
        din   = 4'd0;
        key_i = 1'b1;
        reset = 1'b1;
        #1;
        chk("rst_async_init", {6'd0, key_o}, 7'd0);
        tick();
        tick();
        reset = 1'b0;
        latency(lat);
        chk("rst_release_lat", lat[6:0], 7'd6);

        // Asynchronous reset while key_o is high.
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_mid", {6'd0, key_o}, 7'd0);
        tick();
        reset = 1'b0;
        key_i = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // 3-clock pulse is a bounce: key_o stays low.
        key_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        key_i = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("short_pulse", {6'd0, key_o}, 7'd0);

        // Clean rising and falling steps.
        key_i = 1'b1;
        latency(lat);
        chk("rise_lat", lat[6:0], 7'd6);
        key_i = 1'b0;
        latency(lat);
        chk("fall_lat", lat[6:0], 7'd6);

        // Five clocks of progress discarded by reset; full requalification.
        key_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_midcount", {6'd0, key_o}, 7'd0);
        tick();
        reset = 1'b0;
        latency(lat);
        chk("rst_restart_lat", lat[6:0], 7'd6);

        // Randomized bouncing runs against the reference model.
        lvl = 1'b1;
        for (int seg = 0; seg < 80; seg++) begin
            lvl   = ~lvl;
            key_i = lvl;
            run   = int'($urandom_range(1, 8));
            for (int i = 0; i < run; i++) tick();
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
        end

        // Decoder sweep.
        for (int d = 0; d < 16; d++) begin
            din = 4'(d);
            #1;
            chk($sformatf("dout_%0d", d), dout, exp_seg[d]);
        end

        // dout independent of clock and reset.
        din = 4'd5;
        #1;
        chk("dout5_idle", dout, 7'b1011011);
        reset = 1'b1;
        #1;
        chk("dout5_rst", dout, 7'b1011011);
        tick();
        chk("dout5_rst_clk", dout, 7'b1011011);
        reset = 1'b0;
        tick();
        chk("dout5_run", dout, 7'b1011011);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/debounce_bcd7.md
DEBOUNCE_BCD7 -- requirements
Module: debounce_bcd7

Interface
REQ-001 Parameter: DB_CYCLES, default 500000, consecutive stable clocks required before key_o follows key_i (10 ms at 50 MHz); legal range >= 1.
REQ-002 Parameter: SYNC_STAGES, default 2, synchronizer flops on key_i; legal range >= 2.
REQ-003 Port: clk  input  1  single system clock; all state on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: key_i  input  1  raw, bouncing, asynchronous push-button level.
REQ-006 Port: key_o  output  1  debounced level of key_i, registered.
REQ-007 Port: din  input  4  binary/BCD digit to display.
REQ-008 Port: dout  output  7 ([0:6])  segment drive, dout[0]=a, dout[1]=b, ... dout[6]=g; 1 = segment lit (active-high).

Function
REQ-009 key_i SHALL pass through SYNC_STAGES flops before any use; the last stage is the sampled key.
REQ-010 A stable-counter of width $clog2(DB_CYCLES+1) SHALL increment each clock while the sampled key differs from key_o, and clear to 0 on any clock where they are equal.
REQ-011 key_o SHALL take the sampled key value on the clock where the counter would reach DB_CYCLES; the counter SHALL then clear.
REQ-012 Latency from a clean key_i edge to the key_o change SHALL be exactly SYNC_STAGES + DB_CYCLES clocks.
REQ-013 Any bounce shorter than DB_CYCLES clocks SHALL clear the counter and leave key_o unchanged; the counter SHALL never wrap.
REQ-014 key_o SHALL change at most once per DB_CYCLES clocks and SHALL be glitch-free (flop output).
REQ-015 dout SHALL be a purely combinational function of din, with zero clock latency and independent of clk/reset.
REQ-016 Encodings (dout[0:6], abcdefg): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-017 din 10..15 SHALL follow REQ-024.

Reset
REQ-018 reset asserted SHALL asynchronously force all synchronizer flops to 0, the counter to 0 and key_o to 0.
REQ-019 Reset SHALL dominate any simultaneous key activity; reset mid-count SHALL discard progress, and after deassertion a full SYNC_STAGES + DB_CYCLES qualification SHALL be required.
REQ-020 Reset deassertion SHALL be treated as synchronous to clk by the integrator; no internal reset synchronizer.
REQ-021 dout SHALL be unaffected by reset.

Configuration
REQ-022 Macro: BCD7_HEX_EN.
REQ-023 Without BCD7_HEX_EN: din 10..15 SHALL drive dout=0000000 (blank).
REQ-024 With BCD7_HEX_EN: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111; without it, REQ-023 applies.

Structure
REQ-025 Package debounce_bcd7_pkg SHALL hold the typedef seg_t (logic [0:6]), the constants SEG_0..SEG_9, SEG_A..SEG_F and SEG_BLANK, and DB_CYCLES_DEFAULT.
REQ-026 The decoder SHALL be a sub-module bcd7_decoder (din -> dout), instantiated once; the debounce logic SHALL be top-level RTL.

Verification (DB_CYCLES=4, SYNC_STAGES=2)
REQ-027 Assert reset with key_i=1 -> key_o=0 immediately (asynchronously); after release, key_o=1 exactly 6 clocks later.
REQ-028 Hold key_i at 1 for 3 clocks, then 0 -> key_o stays 0 indefinitely.
REQ-029 Clean 0->1 step on key_i -> key_o rises on clock 6; a 1->0 step rises... falls on clock 6 likewise.
REQ-030 Hold key_i at 1 for 5 clocks, then assert reset -> key_o=0; the counter restarts from 0 after release.
REQ-031 Sweep din 0..15 -> dout matches REQ-016; 10..15 give 0000000 without BCD7_HEX_EN and A..F glyphs with it.
REQ-032 Toggle clk and reset while din is held at 5 -> dout stays 1011011.
